// File: rtl/dispatch_buffer_if.sv
// dispatch_buffer_if: entry type plus the decode/CDB/issue/retire bundle for the dispatch buffer.
package dispatch_buffer_pkg;
    localparam int Q_W = 4;
    typedef enum logic {S_NOT_EXECUTED = 1'b0, S_EXECUTING = 1'b1} e_state_t;
    typedef struct packed {
        logic [7:0]     tag;
        e_state_t       e_state;
        logic [7:0]     op;
        logic [Q_W-1:0] qj;
        logic [Q_W-1:0] qk;
        logic [31:0]    vj;
        logic [31:0]    vk;
    } entry_t;
endpackage

interface dispatch_buffer_if
    import dispatch_buffer_pkg::*;
#(
    parameter int BUF_SIZE     = 8,
    parameter int BUF_SIZE_LOG = 3
);
    logic [1:0]                         in_valid;
    entry_t [1:0]                       in_entry;
    logic                               in_ready;
    logic                               cdb_valid;
    logic [Q_W-1:0]                     cdb_q;
    logic [31:0]                        cdb_value;
    logic [1:0]                         issue_valid;
    logic [1:0][BUF_SIZE_LOG-1:0]       issue_idx;
    logic [1:0]                         retire_valid;
    logic [1:0][BUF_SIZE_LOG-1:0]       retire_idx;
    entry_t [BUF_SIZE-1:0]              entries;
    logic [BUF_SIZE_LOG:0]              free_count;

    modport master (
        output in_valid, in_entry, cdb_valid, cdb_q, cdb_value,
               issue_valid, issue_idx, retire_valid, retire_idx,
        input  in_ready, entries, free_count
    );
    modport slave (
        input  in_valid, in_entry, cdb_valid, cdb_q, cdb_value,
               issue_valid, issue_idx, retire_valid, retire_idx,
        output in_ready, entries, free_count
    );
endinterface

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: age-tagged instruction entry buffer with dual allocate, CDB wakeup, issue marking and retire.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int BUF_SIZE     = 8,
    parameter int BUF_SIZE_LOG = 3
) (
    input logic               clk,
    input logic               reset,
    input logic               flush,
    dispatch_buffer_if.slave  bus
);
    entry_t [BUF_SIZE-1:0] ents, nxt;
    logic [BUF_SIZE_LOG:0] free_count, fc_nxt;
    logic acc0, acc1, f0, f1;
    logic [1:0] n, nret;
    logic [BUF_SIZE_LOG-1:0] s0, s1;
    logic [BUF_SIZE-1:0] ret;
    logic [7:0] r;

    function automatic entry_t wake(entry_t e, logic v, logic [Q_W-1:0] q, logic [31:0] val);
        entry_t w;
        w = e;
        if (v && e.qj == q) begin
            w.qj = '0;
            w.vj = val;
        end
        if (v && e.qk == q) begin
            w.qk = '0;
            w.vk = val;
        end
        return w;
    endfunction

    assign bus.in_ready   = free_count >= (BUF_SIZE_LOG+1)'(2);
    assign bus.entries    = ents;
    assign bus.free_count = free_count;

    always_comb begin
        nxt  = ents;
        ret  = '0;
        nret = '0;
        s0   = '0;
        s1   = '0;
        f0   = 1'b0;
        f1   = 1'b0;
        r    = '0;
        acc0 = bus.in_valid[0] && bus.in_ready;
        acc1 = acc0 && bus.in_valid[1];
        n    = {1'b0, acc0} + {1'b0, acc1};
        // free-slot search uses registered tags, so same-cycle retires are not reused
        for (int i = 0; i < BUF_SIZE; i++) begin
            ret[i] = ((bus.retire_valid[0] && bus.retire_idx[0] == BUF_SIZE_LOG'(i)) ||
                      (bus.retire_valid[1] && bus.retire_idx[1] == BUF_SIZE_LOG'(i))) && ents[i].tag != '0;
            nret = nret + {1'b0, ret[i]};
            if (ents[i].tag == '0 && !f0) begin
                s0 = BUF_SIZE_LOG'(i);
                f0 = 1'b1;
            end else if (ents[i].tag == '0 && !f1) begin
                s1 = BUF_SIZE_LOG'(i);
                f1 = 1'b1;
            end
        end
        for (int i = 0; i < BUF_SIZE; i++) begin
            r = '0;
            for (int j = 0; j < BUF_SIZE; j++)
                r = r + {7'b0, ret[j] && ents[j].tag < ents[i].tag};
            if (ret[i]) begin
                nxt[i].tag     = '0;
                nxt[i].e_state = S_NOT_EXECUTED;
            end else if (ents[i].tag != '0) begin
                nxt[i]     = wake(ents[i], bus.cdb_valid, bus.cdb_q, bus.cdb_value);
                nxt[i].tag = ents[i].tag + {6'b0, n} - r;
                if ((bus.issue_valid[0] && bus.issue_idx[0] == BUF_SIZE_LOG'(i)) ||
                    (bus.issue_valid[1] && bus.issue_idx[1] == BUF_SIZE_LOG'(i)))
                    nxt[i].e_state = S_EXECUTING;
            end
        end
        if (acc0) begin
            nxt[s0]         = wake(bus.in_entry[0], bus.cdb_valid, bus.cdb_q, bus.cdb_value);
            nxt[s0].tag     = acc1 ? 8'd2 : 8'd1;
            nxt[s0].e_state = S_NOT_EXECUTED;
        end
        if (acc1) begin
            nxt[s1]         = wake(bus.in_entry[1], bus.cdb_valid, bus.cdb_q, bus.cdb_value);
            nxt[s1].tag     = 8'd1;
            nxt[s1].e_state = S_NOT_EXECUTED;
        end
        fc_nxt = free_count - (BUF_SIZE_LOG+1)'(n) + (BUF_SIZE_LOG+1)'(nret);
        if (flush) begin
            for (int i = 0; i < BUF_SIZE; i++) begin
                nxt[i]         = ents[i];
                nxt[i].tag     = '0;
                nxt[i].e_state = S_NOT_EXECUTED;
            end
            fc_nxt = (BUF_SIZE_LOG+1)'(BUF_SIZE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ents       <= '0;
            free_count <= (BUF_SIZE_LOG+1)'(BUF_SIZE);
        end else begin
            ents       <= nxt;
            free_count <= fc_nxt;
        end
    end
endmodule

// File: tb/tb_dispatch_buffer.sv
// tb_dispatch_buffer: directed scoreboard bench for dispatch_buffer.
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    localparam int K_TAG = 0, K_FC = 1, K_RDY = 2, K_QJ = 3, K_VJ = 4, K_QK = 5, K_VK = 6, K_ST = 7, K_OP = 8;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    chk_t sb[$];

    dispatch_buffer_if #(.BUF_SIZE(8), .BUF_SIZE_LOG(3)) bus ();
    dispatch_buffer #(.BUF_SIZE(8), .BUF_SIZE_LOG(3)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));

    always #5 clk = ~clk;

    function automatic entry_t mk(logic [7:0] op, logic [3:0] qj, logic [3:0] qk);
        entry_t e;
        e.tag     = 8'hFF;
        e.e_state = S_EXECUTING;
        e.op      = op;
        e.qj      = qj;
        e.qk      = qk;
        e.vj      = 32'h0;
        e.vk      = 32'h0;
        return e;
    endfunction

    function automatic logic [31:0] obs(int kind, int idx);
        case (kind)
            K_TAG:   return 32'(bus.entries[idx].tag);
            K_FC:    return 32'(bus.free_count);
            K_RDY:   return 32'(bus.in_ready);
            K_QJ:    return 32'(bus.entries[idx].qj);
            K_VJ:    return bus.entries[idx].vj;
            K_QK:    return 32'(bus.entries[idx].qk);
            K_VK:    return bus.entries[idx].vk;
            K_ST:    return 32'(bus.entries[idx].e_state);
            default: return 32'(bus.entries[idx].op);
        endcase
    endfunction

    task automatic expect_v(string name, int kind, int idx, logic [31:0] v);
        sb.push_back('{name, kind, idx, v});
    endtask

    task automatic check();
        chk_t c;
        logic [31:0] o;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            o = obs(c.kind, c.idx);
            n_cmp++;
            assert (o === c.exp) else begin
                n_err++;
                $error("FAIL %s[%0d]: observed %0h expected %0h", c.name, c.idx, o, c.exp);
            end
        end
    endtask

    task automatic idle();
        flush            = 1'b0;
        bus.in_valid     = 2'b00;
        bus.in_entry[0]  = mk(8'h00, 4'd0, 4'd0);
        bus.in_entry[1]  = mk(8'h00, 4'd0, 4'd0);
        bus.cdb_valid    = 1'b0;
        bus.cdb_q        = 4'd0;
        bus.cdb_value    = 32'h0;
        bus.issue_valid  = 2'b00;
        bus.issue_idx    = '0;
        bus.retire_valid = 2'b00;
        bus.retire_idx   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic tags(int t0, int t1, int t2, int t3, int t4, int t5, int t6, int t7);
        int t[8];
        t = '{t0, t1, t2, t3, t4, t5, t6, t7};
        for (int i = 0; i < 8; i++) expect_v("tag", K_TAG, i, 32'(t[i]));
    endtask

    initial begin
        idle();
        #12;
        expect_v("rst_fc", K_FC, 0, 32'd8);
        expect_v("rst_rdy", K_RDY, 0, 32'd1);
        expect_v("rst_tag", K_TAG, 0, 32'd0);
        expect_v("rst_tag", K_TAG, 7, 32'd0);
        check();
        @(negedge clk);
        reset = 1'b0;
        // dual dispatch
        bus.in_valid    = 2'b11;
        bus.in_entry[0] = mk(8'hA0, 4'd0, 4'd0);
        bus.in_entry[1] = mk(8'hA1, 4'd0, 4'd0);
        expect_v("fc", K_FC, 0, 32'd6);
        expect_v("st_new", K_ST, 0, 32'(S_NOT_EXECUTED));
        expect_v("op", K_OP, 1, 32'hA1);
        tags(2, 1, 0, 0, 0, 0, 0, 0);
        tick();
        // single dispatch
        idle();
        bus.in_valid    = 2'b01;
        bus.in_entry[0] = mk(8'hA2, 4'd0, 4'd0);
        expect_v("fc", K_FC, 0, 32'd5);
        tags(3, 2, 1, 0, 0, 0, 0, 0);
        tick();
        // lane 1 alone is ignored
        idle();
        bus.in_valid    = 2'b10;
        bus.in_entry[1] = mk(8'hEE, 4'd0, 4'd0);
        expect_v("fc_lane1_only", K_FC, 0, 32'd5);
        tags(3, 2, 1, 0, 0, 0, 0, 0);
        tick();
        idle();
        bus.in_valid    = 2'b11;
        bus.in_entry[0] = mk(8'hA3, 4'd0, 4'd0);
        bus.in_entry[1] = mk(8'hA4, 4'd0, 4'd0);
        expect_v("fc", K_FC, 0, 32'd3);
        tags(5, 4, 3, 2, 1, 0, 0, 0);
        tick();
        idle();
        bus.in_valid    = 2'b01;
        bus.in_entry[0] = mk(8'hA5, 4'd5, 4'd0);
        expect_v("fc", K_FC, 0, 32'd2);
        expect_v("rdy", K_RDY, 0, 32'd1);
        expect_v("qj_wait", K_QJ, 5, 32'd5);
        tick();
        idle();
        bus.in_valid    = 2'b01;
        bus.in_entry[0] = mk(8'hA6, 4'd0, 4'd0);
        expect_v("fc_full", K_FC, 0, 32'd1);
        expect_v("rdy_full", K_RDY, 0, 32'd0);
        tags(7, 6, 5, 4, 3, 2, 1, 0);
        tick();
        // full: no allocation despite retire of the oldest; wakeup on slot 5
        idle();
        bus.in_valid     = 2'b11;
        bus.retire_valid = 2'b01;
        bus.retire_idx[0] = 3'd0;
        bus.cdb_valid    = 1'b1;
        bus.cdb_q        = 4'd5;
        bus.cdb_value    = 32'hDEAD;
        expect_v("fc_retire", K_FC, 0, 32'd2);
        expect_v("rdy_retire", K_RDY, 0, 32'd1);
        expect_v("qj_wake", K_QJ, 5, 32'd0);
        expect_v("vj_wake", K_VJ, 5, 32'hDEAD);
        tags(0, 6, 5, 4, 3, 2, 1, 0);
        tick();
        // retire tag-2 (slot 5) during dual dispatch with bypass on lane 0
        idle();
        bus.in_valid      = 2'b11;
        bus.in_entry[0]   = mk(8'hB0, 4'd0, 4'd5);
        bus.in_entry[1]   = mk(8'hB1, 4'd0, 4'd0);
        bus.retire_valid  = 2'b01;
        bus.retire_idx[0] = 3'd5;
        bus.cdb_valid     = 1'b1;
        bus.cdb_q         = 4'd5;
        bus.cdb_value     = 32'hDEAD;
        expect_v("fc_mix", K_FC, 0, 32'd1);
        expect_v("qk_bypass", K_QK, 0, 32'd0);
        expect_v("vk_bypass", K_VK, 0, 32'hDEAD);
        expect_v("op_lane1", K_OP, 7, 32'hB1);
        tags(2, 7, 6, 5, 4, 0, 3, 1);
        tick();
        // issue + retire same slot 3; issue slot 4
        idle();
        bus.issue_valid   = 2'b11;
        bus.issue_idx[0]  = 3'd3;
        bus.issue_idx[1]  = 3'd4;
        bus.retire_valid  = 2'b01;
        bus.retire_idx[0] = 3'd3;
        expect_v("fc", K_FC, 0, 32'd2);
        expect_v("st_retired", K_ST, 3, 32'(S_NOT_EXECUTED));
        expect_v("st_issued", K_ST, 4, 32'(S_EXECUTING));
        expect_v("st_untouched", K_ST, 0, 32'(S_NOT_EXECUTED));
        tags(2, 6, 5, 0, 4, 0, 3, 1);
        tick();
        // issue of an empty slot on both ports
        idle();
        bus.issue_valid  = 2'b11;
        bus.issue_idx[0] = 3'd3;
        bus.issue_idx[1] = 3'd3;
        expect_v("st_empty_issue", K_ST, 3, 32'(S_NOT_EXECUTED));
        expect_v("fc", K_FC, 0, 32'd2);
        tags(2, 6, 5, 0, 4, 0, 3, 1);
        tick();
        // both retire ports on the same slot count once
        idle();
        bus.retire_valid  = 2'b11;
        bus.retire_idx[0] = 3'd7;
        bus.retire_idx[1] = 3'd7;
        expect_v("fc_dup_retire", K_FC, 0, 32'd3);
        tags(1, 5, 4, 0, 3, 0, 2, 0);
        tick();
        // flush during dual dispatch
        idle();
        flush        = 1'b1;
        bus.in_valid = 2'b11;
        expect_v("fc_flush", K_FC, 0, 32'd8);
        expect_v("st_flush", K_ST, 4, 32'(S_NOT_EXECUTED));
        tags(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        bus.in_valid    = 2'b11;
        bus.in_entry[0] = mk(8'hC0, 4'd0, 4'd0);
        bus.in_entry[1] = mk(8'hC1, 4'd0, 4'd0);
        expect_v("fc", K_FC, 0, 32'd6);
        tags(2, 1, 0, 0, 0, 0, 0, 0);
        tick();
        // asynchronous reset during dual dispatch
        @(negedge clk);
        reset = 1'b1;
        #1;
        expect_v("fc_async", K_FC, 0, 32'd8);
        expect_v("rdy_async", K_RDY, 0, 32'd1);
        tags(0, 0, 0, 0, 0, 0, 0, 0);
        check();
        @(posedge clk);
        #1;
        expect_v("fc_held", K_FC, 0, 32'd8);
        expect_v("tag_held", K_TAG, 0, 32'd0);
        check();
        @(negedge clk);
        reset = 1'b0;
        idle();
        expect_v("fc_idle", K_FC, 0, 32'd8);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
